// File: rtl/debug_serial_sender.sv
// debug_serial_sender: small FIFO feeding a start/data/stop serializer.
// Each serial bit is held for CLK_DIV clock cycles; line idles high.
// Optional feature macro: DEBUG_SERIAL_SENDER_PARITY_EN adds an even-parity
// bit between the last data bit and the stop bit.
module debug_serial_sender #(
    parameter int DATA_WIDTH = 40,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 110,
    parameter int MSB_FIRST  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          in_ready,
    output logic                          sout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int DIV_W = 16;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef DEBUG_SERIAL_SENDER_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

`ifdef DEBUG_SERIAL_SENDER_PARITY_EN
    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] word);
        return ^word;
    endfunction
`endif

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ready_q, ready_d;
    logic                  push_s, pop_s;

    // Serializer state
    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  sout_q, sout_d;
    logic                  busy_q, busy_d;
`ifdef DEBUG_SERIAL_SENDER_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    assign push_s     = in_valid && ready_q;
    assign in_ready   = ready_q;
    assign sout       = sout_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

    // FIFO pointer/count next-state; ready is precomputed from the next count
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d < DEPTH_C);
    end

    // Serializer next-state: divider, bit index, shift register, line level
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        pop_s    = 1'b0;
`ifdef DEBUG_SERIAL_SENDER_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (count_q != CNT_W'(0)) begin
                    pop_s    = 1'b1;
                    shreg_d  = mem_q[rd_ptr_q];
`ifdef DEBUG_SERIAL_SENDER_PARITY_EN
                    parity_d = even_parity(mem_q[rd_ptr_q]);
`endif
                    state_d  = S_START;
                    div_d    = DIV_LAST;
                    bit_d    = BIT_W'(0);
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_START: begin
                if (div_q == DIV_W'(0)) begin
                    state_d = S_DATA;
                    div_d   = DIV_LAST;
                    bit_d   = BIT_W'(0);
                end else begin
                    div_d   = div_q - DIV_W'(1);
                end
            end
            S_DATA: begin
                if (div_q == DIV_W'(0)) begin
                    div_d = DIV_LAST;
                    if (bit_q == BIT_LAST) begin
`ifdef DEBUG_SERIAL_SENDER_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        if (MSB_FIRST != 0) begin
                            shreg_d = shreg_q << 1;
                        end else begin
                            shreg_d = shreg_q >> 1;
                        end
                    end
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
`ifdef DEBUG_SERIAL_SENDER_PARITY_EN
            S_PARITY: begin
                if (div_q == DIV_W'(0)) begin
                    state_d = S_STOP;
                    div_d   = DIV_LAST;
                end else begin
                    div_d   = div_q - DIV_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (div_q == DIV_W'(0)) begin
                    if (count_q != CNT_W'(0)) begin
                        // back-to-back frame: no idle cycle between stop and start
                        pop_s    = 1'b1;
                        shreg_d  = mem_q[rd_ptr_q];
`ifdef DEBUG_SERIAL_SENDER_PARITY_EN
                        parity_d = even_parity(mem_q[rd_ptr_q]);
`endif
                        state_d  = S_START;
                        div_d    = DIV_LAST;
                        bit_d    = BIT_W'(0);
                    end else begin
                        state_d  = S_IDLE;
                        div_d    = DIV_W'(0);
                    end
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                div_d   = DIV_W'(0);
            end
        endcase

        // line level follows the state being entered so sout lines up with it
        case (state_d)
            S_IDLE:   sout_d = 1'b1;
            S_START:  sout_d = 1'b0;
            S_DATA:   sout_d = (MSB_FIRST != 0) ? shreg_d[DATA_WIDTH-1] : shreg_d[0];
`ifdef DEBUG_SERIAL_SENDER_PARITY_EN
            S_PARITY: sout_d = parity_d;
`endif
            S_STOP:   sout_d = 1'b1;
            default:  sout_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // FIFO word storage; contents need no reset since count gates reads
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // All control state with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
            ready_q  <= 1'b1;
            state_q  <= S_IDLE;
            div_q    <= DIV_W'(0);
            bit_q    <= BIT_W'(0);
            shreg_q  <= '0;
            sout_q   <= 1'b1;
            busy_q   <= 1'b0;
`ifdef DEBUG_SERIAL_SENDER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            sout_q   <= sout_d;
            busy_q   <= busy_d;
`ifdef DEBUG_SERIAL_SENDER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_debug_serial_sender.sv
// Directed testbench for debug_serial_sender (DATA_WIDTH=8, FIFO_DEPTH=4, CLK_DIV=4).
// Cycle 0 is the cycle in which the first word of a scenario is presented.
module tb_debug_serial_sender;

    localparam int W   = 8;
    localparam int D   = 4;
    localparam int DIV = 4;
`ifdef DEBUG_SERIAL_SENDER_PARITY_EN
    localparam int FL  = W + 3;
`else
    localparam int FL  = W + 2;
`endif
    localparam int P   = FL * DIV;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready, sout, busy;
    logic [2:0] fifo_count;
    logic       in_ready_l, sout_l, busy_l;
    logic [2:0] fifo_count_l;

    int checks = 0;
    int passed = 0;

    debug_serial_sender #(.DATA_WIDTH(W), .FIFO_DEPTH(D), .CLK_DIV(DIV), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .sout(sout), .busy(busy), .fifo_count(fifo_count)
    );

    debug_serial_sender #(.DATA_WIDTH(W), .FIFO_DEPTH(D), .CLK_DIV(DIV), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_l), .sout(sout_l), .busy(busy_l), .fifo_count(fifo_count_l)
    );

    always #5 clk = ~clk;

    // Expected line level for frame bit k of word w (start, data, [parity], stop).
    function automatic logic frame_bit(input logic [7:0] w, input int k, input bit msb);
        logic [7:0] t;
        t = w;
        if (k == 0) return 1'b0;
        if (k <= W) return msb ? t[W-k] : t[k-1];
`ifdef DEBUG_SERIAL_SENDER_PARITY_EN
        if (k == W + 1) return ^t;
`endif
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++; if (sout !== 1'b1) $display("FAIL reset_sout got=%b exp=1", sout); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", in_ready); else passed++;
        checks++; if (fifo_count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", fifo_count); else passed++;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++; if (sout !== 1'b1) $display("FAIL post_reset_sout got=%b exp=1", sout); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL post_reset_busy got=%b exp=0", busy); else passed++;
    endtask

    task automatic test_single();
        logic es, eb;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        for (int c = 0; c < P + 6; c++) begin
            @(negedge clk);
            es = (c >= 2 && c < 2 + P) ? frame_bit(8'hA5, (c - 2) / DIV, 1'b1) : 1'b1;
            eb = (c >= 2 && c < 2 + P);
            checks++; if (sout !== es) $display("FAIL single_sout cyc=%0d got=%b exp=%b", c, sout, es); else passed++;
            checks++; if (busy !== eb) $display("FAIL single_busy cyc=%0d got=%b exp=%b", c, busy, eb); else passed++;
            if (c == 1) begin
                checks++; if (fifo_count !== 3'd1) $display("FAIL single_count1 got=%0d exp=1", fifo_count); else passed++;
            end
            if (c == 2) begin
                checks++; if (fifo_count !== 3'd0) $display("FAIL single_count2 got=%0d exp=0", fifo_count); else passed++;
            end
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic test_bit_order();
        logic [0:7] seq_m;
        logic [0:7] seq_l;
        int         k;
        seq_m    = 8'b0000_0001;
        seq_l    = 8'b1000_0000;
        in_valid = 1'b1;
        in_data  = 8'h01;
        for (int c = 0; c < P + 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++; if (fifo_count_l !== 3'd1) $display("FAIL order_lsb_count got=%0d exp=1", fifo_count_l); else passed++;
                checks++; if (in_ready_l !== 1'b1) $display("FAIL order_lsb_ready got=%b exp=1", in_ready_l); else passed++;
            end
            if (c == 3) begin
                checks++; if (busy_l !== 1'b1) $display("FAIL order_lsb_busy got=%b exp=1", busy_l); else passed++;
            end
            if (c >= 2 + DIV && c < 2 + DIV * (W + 1) && ((c - 2) % DIV) == 1) begin
                k = (c - 2) / DIV - 1;
                checks++; if (sout !== seq_m[k]) $display("FAIL order_msb bit=%0d got=%b exp=%b", k, sout, seq_m[k]); else passed++;
                checks++; if (sout_l !== seq_l[k]) $display("FAIL order_lsb bit=%0d got=%b exp=%b", k, sout_l, seq_l[k]); else passed++;
            end
            tick();
            in_valid = 1'b0;
        end
    endtask

`ifdef DEBUG_SERIAL_SENDER_PARITY_EN
    task automatic send_and_check_parity(input logic [7:0] w, input logic exp_par);
        in_valid = 1'b1;
        in_data  = w;
        for (int c = 0; c < P + 4; c++) begin
            @(negedge clk);
            if (c >= 2 + DIV * 9 && c < 2 + DIV * 10) begin
                checks++; if (sout !== exp_par) $display("FAIL parity_bit word=%h cyc=%0d got=%b exp=%b", w, c, sout, exp_par); else passed++;
            end
            if (c == 2 + DIV * 10) begin
                checks++; if (sout !== 1'b1) $display("FAIL parity_stop word=%h got=%b exp=1", w, sout); else passed++;
            end
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic test_parity();
        send_and_check_parity(8'h07, 1'b1);
        send_and_check_parity(8'h03, 1'b0);
    endtask
`endif

    task automatic test_back_to_back();
        logic [7:0] words [6];
        int         i;
        int         acc5;
        int         j, o;
        logic       es, eb, er, acc;
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hF0;
        words[3] = 8'h0F; words[4] = 8'h81; words[5] = 8'h7E;
        i        = 0;
        acc5     = -1;
        in_valid = 1'b1;
        in_data  = words[0];
        for (int c = 0; c < 2 + 6 * P + 4; c++) begin
            @(negedge clk);
            if (c >= 2 && c < 2 + 6 * P) begin
                j  = (c - 2) / P;
                o  = (c - 2) % P;
                es = frame_bit(words[j], o / DIV, 1'b1);
                eb = 1'b1;
            end else begin
                es = 1'b1;
                eb = 1'b0;
            end
            checks++; if (sout !== es) $display("FAIL b2b_sout cyc=%0d got=%b exp=%b", c, sout, es); else passed++;
            checks++; if (busy !== eb) $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", c, busy, eb); else passed++;
            if (i < 6) begin
                er = (c < 5 || c >= P + 2);
                checks++; if (in_ready !== er) $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", c, in_ready, er); else passed++;
            end
            acc = in_valid && in_ready;
            if (acc && i == 5) acc5 = c;
            tick();
            if (acc) begin
                i++;
                if (i < 6) in_data = words[i];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++; if (acc5 !== P + 2) $display("FAIL b2b_w5_accept got=%0d exp=%0d", acc5, P + 2); else passed++;
        checks++; if (i !== 6) $display("FAIL b2b_all_accepted got=%0d exp=6", i); else passed++;
    endtask

    task automatic test_reset_midframe();
        in_valid = 1'b1;
        in_data  = 8'h00;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c == 2) in_valid = 1'b0;
        end
        // now in cycle 10: first word in DATA, two words queued
        checks++; if (busy !== 1'b1) $display("FAIL mid_pre_busy got=%b exp=1", busy); else passed++;
        checks++; if (sout !== 1'b0) $display("FAIL mid_pre_sout got=%b exp=0", sout); else passed++;
        checks++; if (fifo_count !== 3'd2) $display("FAIL mid_pre_count got=%0d exp=2", fifo_count); else passed++;
        #1 reset = 1'b1;
        #1;
        checks++; if (sout !== 1'b1) $display("FAIL mid_sout got=%b exp=1", sout); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL mid_busy got=%b exp=0", busy); else passed++;
        checks++; if (fifo_count !== 3'd0) $display("FAIL mid_count got=%0d exp=0", fifo_count); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL mid_ready got=%b exp=1", in_ready); else passed++;
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++; if (sout !== 1'b1) $display("FAIL mid_after_sout cyc=%0d got=%b exp=1", c, sout); else passed++;
            checks++; if (busy !== 1'b0) $display("FAIL mid_after_busy cyc=%0d got=%b exp=0", c, busy); else passed++;
            tick();
        end
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_single();
        test_bit_order();
`ifdef DEBUG_SERIAL_SENDER_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/debug_serial_sender.md
DEBUG_SERIAL_SENDER -- requirements
Module: debug_serial_sender

Interface
REQ-001 Parameter DATA_WIDTH, default 40: payload bits per frame; legal range 1..64.
REQ-002 Parameter FIFO_DEPTH, default 4: words buffered ahead of the serializer; power of two, at least 2.
REQ-003 Parameter CLK_DIV, default 110: clk cycles each serial bit is held; legal range 1..65535.
REQ-004 Parameter MSB_FIRST, default 1: 1 sends payload MSB first; 0 sends LSB first.
REQ-005 clk  input  1: sole clock; all state updates on its rising edge.
REQ-006 reset  input  1: asynchronous, active-high reset.
REQ-007 in_valid  input  1: producer offers in_data this cycle.
REQ-008 in_data  input  DATA_WIDTH: payload word.
REQ-009 in_ready  output  1: FIFO can accept a word this cycle.
REQ-010 sout  output  1: serial line; idle level 1.
REQ-011 busy  output  1: serializer is in any state other than IDLE.
REQ-012 fifo_count  output  $clog2(FIFO_DEPTH)+1: words currently held in the FIFO.

Function
REQ-013 A word shall be accepted only on a cycle where in_valid and in_ready are both 1, and it shall be visible in fifo_count on the next cycle.
REQ-014 in_ready shall be 1 exactly when fifo_count < FIFO_DEPTH; a same-cycle pop shall not make a full FIFO accept a push.
REQ-015 A simultaneous push and pop shall leave fifo_count unchanged; read and write pointers shall wrap modulo FIFO_DEPTH.
REQ-016 Serializer states: IDLE, START, DATA, PARITY (present only with REQ-026), STOP.
REQ-017 In IDLE with fifo_count > 0, the serializer shall pop the head word and enter START on the next cycle; the minimum latency from acceptance to the first start-bit cycle is 2 cycles.
REQ-018 START drives sout=0 for CLK_DIV cycles, then enters DATA.
REQ-019 DATA drives DATA_WIDTH bits, each held for CLK_DIV cycles, in the order set by MSB_FIRST, then enters PARITY (if built) or STOP.
REQ-020 STOP drives sout=1 for CLK_DIV cycles.
REQ-021 On the last STOP cycle, with fifo_count > 0, the serializer shall pop and enter START with no idle gap; otherwise it shall enter IDLE.
REQ-022 The per-bit divider counts CLK_DIV-1 down to 0; the bit index and the state advance only when the divider reaches 0.
REQ-023 A popped word is held in a shift register; FIFO contents and pushes shall not alter a frame in flight.
REQ-024 sout shall be registered, with no combinational path from in_valid or in_data.

Reset
REQ-025 While reset is 1: sout=1, busy=0, in_ready=1, fifo_count=0, state=IDLE, divider and pointers=0; any frame in progress is aborted and buffered words are discarded.

Configuration
REQ-026 Macro DEBUG_SERIAL_SENDER_PARITY_EN:
- Defined: a PARITY state follows DATA and drives the even-parity bit (XOR of the payload) for CLK_DIV cycles; frame length is DATA_WIDTH+3 bits.
- Undefined: no PARITY state is built; frame length is DATA_WIDTH+2 bits.

Verification (DATA_WIDTH=8, FIFO_DEPTH=4, CLK_DIV=4, parity off unless stated)
REQ-027 Single word: push 8'hA5 at cycle 0 -> sout=0 cycles 2-5; then bits 1,0,1,0,0,1,0,1, each held 4 cycles; then 1 cycles 38-41; busy=1 cycles 2-41.
REQ-028 Bit order: with MSB_FIRST=0, push 8'h01 -> data bits 1,0,0,0,0,0,0,0; with MSB_FIRST=1 -> 0,0,0,0,0,0,0,1.
REQ-029 Backpressure: push w0-w5 on cycles 0-5 -> in_ready=0 from cycle 5; w1 popped at cycle 41; in_ready=1 at cycle 42; w5 accepted at cycle 42; frames are contiguous with no idle gap.
REQ-030 Parity: with the macro defined, push 8'h07 -> parity bit 1 held 4 cycles before stop; push 8'h03 -> parity bit 0.
REQ-031 Reset mid-frame: assert reset during DATA with 2 words queued -> sout=1, busy=0, fifo_count=0, in_ready=1 immediately, with no clock edge needed.
